// File: rtl/arm_dec_pkg.sv
// Shared definitions for the A32 decode stage: instruction class codes and
// fixed field positions within a 32-bit instruction word.
package arm_dec_pkg;

  typedef enum logic [3:0] {
    CLS_DP_IMM   = 4'd0,
    CLS_DP_IMMSH = 4'd1,
    CLS_DP_REGSH = 4'd2,
    CLS_MUL      = 4'd3,
    CLS_XLS      = 4'd4,
    CLS_LS       = 4'd5,
    CLS_LDM      = 4'd6,
    CLS_BR       = 4'd7,
    CLS_CP_SWI   = 4'd8,
    CLS_UNDEF    = 4'd9
  } cls_e;

  localparam int NUM_CLS = 10;

  localparam int COND_HI = 31;
  localparam int COND_LO = 28;
  localparam int BIT_I   = 25;
  localparam int OP_HI   = 27;
  localparam int OP_LO   = 25;
  localparam int BIT4    = 4;
  localparam int BIT7    = 7;

endpackage

// File: rtl/arm_dec_classify.sv
// Combinational A32 instruction-class decoder. Looks only at the opcode bits
// [27:25] and [7:4]; the cond field does not influence the class.
module arm_dec_classify
  import arm_dec_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output cls_e               cls
);

  logic [2:0] op;
  logic       unused_bits;

  assign op          = instr[OP_HI:OP_LO];
  assign unused_bits = ^{instr[INSTR_W-1:28], instr[24:8], instr[3:0]};

  // Priority order matters: the UNDEF hole must be checked before the LS catch-all.
  always_comb begin
    cls = CLS_CP_SWI;
    if (op[2:1] == 2'b00 && instr[BIT_I]) begin
      cls = CLS_DP_IMM;
    end else if (op[2:1] == 2'b00) begin
      if (!instr[BIT4])                cls = CLS_DP_IMMSH;
      else if (!instr[BIT7])           cls = CLS_DP_REGSH;
      else if (instr[6:5] == 2'b00)    cls = CLS_MUL;
      else                             cls = CLS_XLS;
    end else if (op == 3'b011 && instr[BIT4]) begin
      cls = CLS_UNDEF;
    end else if (op[2:1] == 2'b01) begin
      cls = CLS_LS;
    end else if (op == 3'b100) begin
      cls = CLS_LDM;
    end else if (op == 3'b101) begin
      cls = CLS_BR;
    end else begin
      cls = CLS_CP_SWI;
    end
  end

endmodule

// File: rtl/arm_decode_stage.sv
// Registered A32 decode stage with valid/ready handshake and a one-entry skid.
// Optional per-class statistics counters are enabled by defining DECODE_STATS_EN.
module arm_decode_stage
  import arm_dec_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_cls,
  output logic [3:0]         out_cond,
  output logic [INSTR_W-1:0] out_instr,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               stat_clr,
  input  logic [3:0]         stat_sel,
  output logic [CNT_W-1:0]   stat_count
);

  cls_e               in_cls;
  logic               in_xfer;
  logic               load_out;
  logic               skid_valid;
  cls_e               skid_cls;
  logic [INSTR_W-1:0] skid_instr;
  logic [TAG_W-1:0]   skid_tag;
  cls_e               out_cls_q;

  arm_dec_classify #(.INSTR_W(INSTR_W)) u_classify (
    .instr (in_instr),
    .cls   (in_cls)
  );

  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && in_ready;
  // Output register may take a new entry whenever it is empty or being drained.
  assign load_out = !out_valid || out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (load_out) out_valid <= skid_valid || in_xfer;
      skid_valid <= load_out ? 1'b0 : (skid_valid || in_xfer);
    end
  end

  // Output register: skid entry always has priority to keep order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_cls_q <= CLS_DP_IMM;
      out_instr <= '0;
      out_tag   <= '0;
    end else if (load_out) begin
      if (skid_valid) begin
        out_cls_q <= skid_cls;
        out_instr <= skid_instr;
        out_tag   <= skid_tag;
      end else if (in_xfer) begin
        out_cls_q <= in_cls;
        out_instr <= in_instr;
        out_tag   <= in_tag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!load_out && in_xfer) begin
      skid_cls   <= in_cls;
      skid_instr <= in_instr;
      skid_tag   <= in_tag;
    end
  end

  assign out_cls  = out_cls_q;
  assign out_cond = out_instr[COND_HI:COND_LO];

`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_CLS];
  logic             count_en;

  assign count_en = in_xfer && !flush;

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CLS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLS; i++) begin
        if (stat_clr)
          cnt[i] <= '0;
        else if (count_en && 4'(in_cls) == 4'(i) && cnt[i] != '1)
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_CLS; i++) begin
      if (stat_sel == 4'(i)) stat_count = cnt[i];
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{stat_clr, stat_sel};
  assign stat_count  = '0;
`endif

endmodule

// File: tb/tb_arm_decode_stage.sv
// Directed self-checking bench for arm_decode_stage; statistics checks adapt
// to whether DECODE_STATS_EN is defined.
module tb_arm_decode_stage;

  localparam int INSTR_W = 32;
  localparam int TAG_W   = 4;
  localparam int CNT_W   = 2;
`ifdef DECODE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [31:0] I_BR  = 32'hEA000000;
  localparam logic [31:0] I_LDM = 32'hE8BD8000;
  localparam logic [31:0] I_DPI = 32'hE3A01005;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [3:0]         out_cls;
  logic [3:0]         out_cond;
  logic [INSTR_W-1:0] out_instr;
  logic [TAG_W-1:0]   out_tag;
  logic               stat_clr = 1'b0;
  logic [3:0]         stat_sel = '0;
  logic [CNT_W-1:0]   stat_count;

  int checks = 0;
  int fails  = 0;

  arm_decode_stage #(.INSTR_W(INSTR_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_cls(out_cls), .out_cond(out_cond),
    .out_instr(out_instr), .out_tag(out_tag),
    .stat_clr(stat_clr), .stat_sel(stat_sel), .stat_count(stat_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ctrl: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_cls !== 4'd0 || out_cond !== 4'd0 || out_instr !== 32'd0 || out_tag !== 4'd0 || stat_count !== 2'd0) begin
      fails++;
      $display("FAIL reset_data: cls=%0d cond=%0h instr=%h tag=%0d cnt=%0d, required all 0",
               out_cls, out_cond, out_instr, out_tag, stat_count);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  task automatic run_stream(input logic [31:0] v [5], input int exp_cls [5], input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = v[i];
      in_tag   = 4'(i + 1);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_cls !== 4'(exp_cls[i]) || out_cond !== 4'hE ||
          out_tag !== 4'(i + 1) || out_instr !== v[i] || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s[%0d]: vld=%b cls=%0d cond=%0h tag=%0d rdy=%b, required 1/%0d/e/%0d/1",
                 name, i, out_valid, out_cls, out_cond, out_tag, in_ready, exp_cls[i], i + 1);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: out_valid=%b, required 0", name, out_valid);
    end
  endtask

  task automatic test_classes_a();
    logic [31:0] v [5];
    int c [5];
    v = '{32'hE3A01005, 32'hE0010392, 32'hEA000000, 32'hE7F000F0, 32'hE5912004};
    c = '{0, 3, 7, 9, 5};
    run_stream(v, c, "cls_a");
  endtask

  task automatic test_classes_b();
    logic [31:0] v [5];
    int c [5];
    v = '{32'hE1A00001, 32'hE1A00211, 32'hE1C020B0, 32'hE8BD8000, 32'hEF000000};
    c = '{1, 2, 4, 6, 8};
    run_stream(v, c, "cls_b");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = I_DPI;
    in_tag    = 4'd1;
    step();
    in_tag = 4'd2;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 4'd1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_fill: rdy=%b vld=%b tag=%0d, required 0/1/1", in_ready, out_valid, out_tag);
    end
    in_tag = 4'd3;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 4'd1 || out_valid !== 1'b1 || out_instr !== I_DPI) begin
      fails++;
      $display("FAIL stall_hold: rdy=%b vld=%b tag=%0d, required 0/1/1", in_ready, out_valid, out_tag);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd2 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL release_2: vld=%b tag=%0d rdy=%b, required 1/2/1", out_valid, out_tag, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd3) begin
      fails++;
      $display("FAIL release_3: vld=%b tag=%0d, required 1/3", out_valid, out_tag);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL release_end: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    stat_clr  = 1'b1;
    step();
    stat_clr  = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = I_LDM;
    in_tag    = 4'd4;
    step();
    in_tag = 4'd5;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_pre: in_ready=%b, required 0", in_ready);
    end
    in_tag = 4'd6;
    flush  = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_ctrl: vld=%b rdy=%b, required 0/1", out_valid, in_ready);
    end
    stat_sel = 4'd6;
    #1;
    checks++;
    if (stat_count !== (STATS ? 2'd2 : 2'd0)) begin
      fails++;
      $display("FAIL flush_count: stat_count=%0d, required %0d", stat_count, STATS ? 2 : 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_ghost[%0d]: out_valid=%b tag=%0d, required 0", i, out_valid, out_tag);
      end
    end
  endtask

  task automatic test_stats();
    logic [1:0] exp;
    out_ready = 1'b1;
    stat_clr  = 1'b1;
    step();
    stat_clr = 1'b0;
    stat_sel = 4'd7;
    in_instr = I_BR;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_tag   = 4'(i);
      step();
      exp = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++;
      if (stat_count !== (STATS ? exp : 2'd0)) begin
        fails++;
        $display("FAIL stat_sat[%0d]: stat_count=%0d, required %0d", i, stat_count, STATS ? exp : 0);
      end
    end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    checks++;
    if (stat_count !== 2'd0) begin
      fails++;
      $display("FAIL stat_clr_prio: stat_count=%0d, required 0", stat_count);
    end
    step();
    in_valid = 1'b0;
    stat_sel = 4'd12;
    #1;
    checks++;
    if (stat_count !== 2'd0) begin
      fails++;
      $display("FAIL stat_sel12: stat_count=%0d, required 0", stat_count);
    end
    stat_sel = 4'd7;
    #1;
    checks++;
    if (stat_count !== (STATS ? 2'd1 : 2'd0)) begin
      fails++;
      $display("FAIL stat_after_clr: stat_count=%0d, required %0d", stat_count, STATS ? 1 : 0);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = I_BR;
    in_tag    = 4'd9;
    step();
    in_valid = 1'b0;
    stat_sel = 4'd7;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd9 || stat_count !== (STATS ? 2'd2 : 2'd0)) begin
      fails++;
      $display("FAIL pre_reset: vld=%b tag=%0d cnt=%0d, required 1/9/%0d",
               out_valid, out_tag, stat_count, STATS ? 2 : 0);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 4'd0 || out_cls !== 4'd0 || stat_count !== 2'd0) begin
      fails++;
      $display("FAIL async_reset: vld=%b rdy=%b tag=%0d cls=%0d cnt=%0d, required 0/1/0/0/0",
               out_valid, in_ready, out_tag, out_cls, stat_count);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_classes_a();
    test_classes_b();
    test_back_to_back();
    test_flush();
    test_stats();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
